clk_period_meter: RTL and testbench

//  Measures a slow, free-running square wave, e.g. the divided_clk output of a counter

---
 rtl/clk_period_meter.sv | 81 ++++++++
 tb/tb_clk_period_meter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of a slow square wave in clk cycles
module clk_period_meter #(
  parameter int COUNT_W        = 32,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sig_in,
  output logic [COUNT_W-1:0] period_out,
  output logic [COUNT_W-1:0] high_out,
  output logic [COUNT_W-1:0] div_est,
  output logic               div_exact,
  output logic               meas_valid,
  output logic               timeout
);
  typedef enum logic [1:0] {IDLE, MEASURE, TIMED_OUT} state_t;
  localparam logic [COUNT_W-1:0] ONE   = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] LIMIT = COUNT_W'(TIMEOUT_CYCLES);
  state_t             state;
  logic               sig_m, sig_s, sig_d;
  logic [COUNT_W-1:0] cnt, hi_cnt;
  logic               rise;
  assign rise = sig_s & ~sig_d;
  // two-flop synchronizer plus a delay flop for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_m <= 1'b0;
      sig_s <= 1'b0;
      sig_d <= 1'b0;
    end else begin
      sig_m <= sig_in;
      sig_s <= sig_m;
      sig_d <= sig_s;
    end
  end
  // measurement FSM; a rise always takes priority over the timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      hi_cnt     <= '0;
      period_out <= '0;
      high_out   <= '0;
      div_est    <= '0;
      div_exact  <= 1'b0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        IDLE: if (rise) begin
          cnt    <= ONE;
          hi_cnt <= ONE;
          state  <= MEASURE;
        end
        MEASURE: if (rise) begin
          period_out <= cnt;
          high_out   <= hi_cnt;
          div_est    <= (cnt >> 1) - ONE;
          div_exact  <= ~cnt[0];
          meas_valid <= 1'b1;
          cnt        <= ONE;
          hi_cnt     <= ONE;
        end else if (cnt == LIMIT) begin
          timeout <= 1'b1;
          state   <= TIMED_OUT;
        end else begin
          cnt    <= cnt + ONE;
          hi_cnt <= hi_cnt + COUNT_W'(sig_s);
        end
        TIMED_OUT: if (rise) begin
          timeout <= 1'b0;
          cnt     <= ONE;
          hi_cnt  <= ONE;
          state   <= MEASURE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed checks of period, high time, divider recovery and timeout
module tb_clk_period_meter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sig_in = 1'b0;
  logic [31:0] period_out, high_out, div_est;
  logic        div_exact, meas_valid, timeout;
  int          checks = 0;
  int          errors = 0;
  int          vcount = 0;
  int          vc;
  int          k;
  logic [31:0] exp_p = 0;
  logic [31:0] exp_h = 0;

  clk_period_meter #(.COUNT_W(32), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .period_out(period_out), .high_out(high_out),
    .div_est(div_est), .div_exact(div_exact), .meas_valid(meas_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // every measurement pulse must carry the period/high time of the wave being driven
  always @(negedge clk) begin
    if (meas_valid) begin
      vcount++;
      checks++;
      assert (period_out === exp_p && high_out === exp_h)
      else begin
        errors++;
        $error("FAIL pulse observed %0d/%0d expected %0d/%0d", period_out, high_out, exp_p, exp_h);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    sig_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    vcount = 0;
  endtask

  task automatic wave(input int hi, input int lo, input int n, input int off);
    for (int i = 0; i < n; i++) begin
      #(off) sig_in = 1'b1;
      repeat (hi) @(negedge clk);
      #(off) sig_in = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [31:0] p, input logic [31:0] h,
                          input logic [31:0] d, input logic x);
    chk({tag, "_period"}, period_out, p);
    chk({tag, "_high"}, high_out, h);
    chk({tag, "_div"}, div_est, d);
    chk({tag, "_exact"}, 32'(div_exact), 32'(x));
  endtask

  initial begin
    @(negedge clk);
    // reset state, and no pulse on the first rise
    do_reset();
    chk_outs("rst", 0, 0, 0, 1'b0);
    chk("rst_valid", 32'(meas_valid), 0);
    chk("rst_timeout", 32'(timeout), 0);
    wave(3, 3, 1, 0);
    repeat (5) @(negedge clk);
    chk("first_rise_novalid", vcount, 0);
    // divider-style wave 5 high / 5 low
    do_reset();
    exp_p = 10; exp_h = 5;
    wave(5, 5, 6, 0);
    repeat (5) @(negedge clk);
    chk("div4_count", vcount, 5);
    chk_outs("div4", 10, 5, 4, 1'b1);
    // odd wave 3 high / 4 low with phase offset
    do_reset();
    exp_p = 7; exp_h = 3;
    wave(3, 4, 5, 3);
    repeat (5) @(negedge clk);
    chk("odd_count", vcount, 4);
    chk_outs("odd", 7, 3, 2, 1'b0);
    // minimum period of 2
    do_reset();
    exp_p = 2; exp_h = 1;
    wave(1, 1, 6, 0);
    repeat (5) @(negedge clk);
    chk("p2_count", vcount, 5);
    chk_outs("p2", 2, 1, 0, 1'b1);
    // timeout 100 cycles after the last rise; latency from drive to timeout is 3 + 100
    do_reset();
    exp_p = 10; exp_h = 5;
    wave(5, 5, 2, 0);
    sig_in = 1'b1;
    k = 0;
    while (k < 300 && !timeout) begin
      @(negedge clk);
      k++;
      if (k == 5) sig_in = 1'b0;
    end
    chk("timeout_latency", k, 103);
    chk("timeout_level", 32'(timeout), 1);
    chk("timeout_count", vcount, 2);
    chk_outs("timeout_hold", 10, 5, 4, 1'b1);
    // restart: first rise clears timeout without a pulse, second rise measures
    exp_p = 8; exp_h = 4;
    vc = vcount;
    wave(4, 4, 2, 0);
    repeat (5) @(negedge clk);
    chk("restart_timeout", 32'(timeout), 0);
    chk("restart_count", vcount - vc, 1);
    chk_outs("restart", 8, 4, 3, 1'b1);
    // rise exactly when cnt reaches the timeout limit
    do_reset();
    exp_p = 100; exp_h = 50;
    wave(50, 50, 3, 0);
    chk("edge_timeout", 32'(timeout), 0);
    chk("edge_count", vcount, 2);
    chk_outs("edge", 100, 50, 49, 1'b1);
    // reset mid-period at cnt 37
    do_reset();
    exp_p = 10; exp_h = 5;
    wave(5, 5, 2, 0);
    sig_in = 1'b1;
    repeat (20) @(negedge clk);
    sig_in = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_outs("midrst", 0, 0, 0, 1'b0);
    chk("midrst_timeout", 32'(timeout), 0);
    exp_p = 6; exp_h = 3;
    vc = vcount;
    wave(3, 3, 3, 0);
    repeat (5) @(negedge clk);
    chk("midrst_count", vcount - vc, 2);
    chk_outs("after_rst", 6, 3, 2, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
